// File: rtl/ofdm_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_sync_pkg
//  Description : Shared state encodings, tracker opcodes, default timing
//                parameters and helpers for the OFDM preamble sync controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ofdm_sync_pkg;

  // Controller state encoding; codes 4..7 are unreachable.
  typedef enum logic [2:0] {
    ST_SEARCH_A = 3'd0,
    ST_PEAK_A   = 3'd1,
    ST_WAIT_B   = 3'd2,
    ST_LOCKED   = 3'd3
  } state_t;

  // Commands from the controller to the peak tracker.
  typedef enum logic [2:0] {
    TRK_HOLD  = 3'd0,
    TRK_CLEAR = 3'd1,
    TRK_LOAD  = 3'd2,
    TRK_TRACK = 3'd3,
    TRK_COUNT = 3'd4
  } trk_op_t;

  localparam int C_DEF_PEAK_WIN = 4;
  localparam int C_DEF_B_OFFSET = 16;
  localparam int C_DEF_B_TOL    = 2;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofdm_peak_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_peak_tracker
//  Description : Holds the running maximum of the A correlation and the
//                saturating distance (in cycles) since that maximum.
//  Revision    : 1.0 - initial release
// ============================================================================
module ofdm_peak_tracker
  import ofdm_sync_pkg::*;
#(
  parameter int DATA_SIZE = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_en,
  input  trk_op_t              i_op,
  input  logic [DATA_SIZE-1:0] i_abs,
  output logic [DATA_SIZE-1:0] o_max_nxt,
  output logic [7:0]           o_dist
);

  logic [DATA_SIZE-1:0] r_max;
  logic [7:0]           r_since;
  logic [DATA_SIZE-1:0] w_max_nxt;
  logic [7:0]           w_since_nxt;

  // Next max/distance; a strict compare keeps the earlier peak on ties.
  always_comb begin
    w_max_nxt   = r_max;
    w_since_nxt = r_since;
    unique case (i_op)
      TRK_CLEAR: begin
        w_max_nxt   = '0;
        w_since_nxt = '0;
      end
      TRK_LOAD: begin
        w_max_nxt   = i_abs;
        w_since_nxt = '0;
      end
      TRK_TRACK: begin
        if (i_abs > r_max) begin
          w_max_nxt   = i_abs;
          w_since_nxt = '0;
        end else begin
          w_since_nxt = sat_inc8(r_since);
        end
      end
      TRK_COUNT: w_since_nxt = sat_inc8(r_since);
      default: ;
    endcase
  end

  // Tracker registers, frozen while the clock enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max   <= '0;
      r_since <= '0;
    end else if (i_en) begin
      r_max   <= w_max_nxt;
      r_since <= w_since_nxt;
    end
  end

  // Distance of the current cycle from the peak cycle.
  assign o_max_nxt = w_max_nxt;
  assign o_dist    = sat_inc8(r_since);

endmodule
`default_nettype wire

// File: rtl/ofdm_preamble_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_preamble_sync_ctrl
//  Description : Preamble-A peak search followed by a timed preamble-B check;
//                on a B crossing inside the tolerance window the frame is
//                locked for FRAME_LEN cycles and frame_start pulses once.
//  Revision    : 1.0 - initial release
// ============================================================================
module ofdm_preamble_sync_ctrl
  import ofdm_sync_pkg::*;
#(
  parameter int DATA_SIZE = 48,
  parameter int PEAK_WIN  = C_DEF_PEAK_WIN,
  parameter int B_OFFSET  = C_DEF_B_OFFSET,
  parameter int B_TOL     = C_DEF_B_TOL,
  parameter int FRAME_LEN = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 rearm,
  input  logic [DATA_SIZE-1:0] abs_a,
  input  logic [DATA_SIZE-1:0] porog_a,
  input  logic [DATA_SIZE-1:0] abs_b,
  input  logic [DATA_SIZE-1:0] porog_b,
  output logic                 frame_start,
  output logic                 locked,
  output logic [DATA_SIZE-1:0] peak_a,
  output logic [7:0]           b_delay,
  output logic [7:0]           miss_cnt,
  output logic [2:0]           o_state
);

  localparam int WIN_W = $clog2(PEAK_WIN + 1);
  localparam int TMR_W = $clog2(FRAME_LEN + 1);
  localparam logic [7:0] C_WIN_LO = 8'(B_OFFSET - B_TOL);
  localparam logic [7:0] C_WIN_HI = 8'(B_OFFSET + B_TOL);

  state_t               r_state, w_state_nxt;
  logic [WIN_W-1:0]     r_win, w_win_nxt, w_win_inc;
  logic [TMR_W-1:0]     r_tmr, w_tmr_nxt;
  logic [DATA_SIZE-1:0] r_peak;
  logic [7:0]           r_bdly;
  logic [7:0]           r_miss;
  logic                 r_fs;
  trk_op_t              w_trk_op;
  logic                 w_lock, w_miss, w_load_peak;
  logic                 w_a_hit, w_b_hit, w_in_win;
  logic [DATA_SIZE-1:0] w_max_nxt;
  logic [7:0]           w_dist;

  assign w_a_hit   = abs_a > porog_a;
  assign w_b_hit   = abs_b > porog_b;
  assign w_in_win  = (w_dist >= C_WIN_LO) && (w_dist <= C_WIN_HI);
  assign w_win_inc = r_win + WIN_W'(1);

  ofdm_peak_tracker #(
    .DATA_SIZE (DATA_SIZE)
  ) u_peak (
    .clk       (clk),
    .reset     (reset),
    .i_en      (en),
    .i_op      (w_trk_op),
    .i_abs     (abs_a),
    .o_max_nxt (w_max_nxt),
    .o_dist    (w_dist)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_SEARCH_A;
    else if (en) r_state <= w_state_nxt;
  end

  // Next-state and control decode; rearm overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_trk_op    = TRK_HOLD;
    w_win_nxt   = r_win;
    w_tmr_nxt   = r_tmr;
    w_lock      = 1'b0;
    w_miss      = 1'b0;
    w_load_peak = 1'b0;
    if (rearm) begin
      w_state_nxt = ST_SEARCH_A;
      w_trk_op    = TRK_CLEAR;
      w_win_nxt   = '0;
      w_tmr_nxt   = '0;
    end else begin
      case (r_state)
        ST_SEARCH_A: begin
          if (w_a_hit) begin
            w_trk_op  = TRK_LOAD;
            w_win_nxt = WIN_W'(1);
            if (PEAK_WIN <= 1) begin
              w_state_nxt = ST_WAIT_B;
              w_load_peak = 1'b1;
              w_win_nxt   = '0;
            end else begin
              w_state_nxt = ST_PEAK_A;
            end
          end
        end
        ST_PEAK_A: begin
          w_trk_op  = TRK_TRACK;
          w_win_nxt = w_win_inc;
          if (w_win_inc == WIN_W'(PEAK_WIN)) begin
            w_state_nxt = ST_WAIT_B;
            w_load_peak = 1'b1;
            w_win_nxt   = '0;
          end
        end
        ST_WAIT_B: begin
          w_trk_op = TRK_COUNT;
          if (w_b_hit && w_in_win) begin
            w_state_nxt = ST_LOCKED;
            w_lock      = 1'b1;
            w_tmr_nxt   = '0;
          end else if (w_dist > C_WIN_HI) begin
            w_state_nxt = ST_SEARCH_A;
            w_miss      = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (r_tmr == TMR_W'(FRAME_LEN - 1)) begin
            w_state_nxt = ST_SEARCH_A;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        default: w_state_nxt = ST_SEARCH_A;
      endcase
    end
  end

  // Timers, captured results and the pending frame_start flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win  <= '0;
      r_tmr  <= '0;
      r_peak <= '0;
      r_bdly <= '0;
      r_miss <= '0;
      r_fs   <= 1'b0;
    end else if (en) begin
      r_win <= w_win_nxt;
      r_tmr <= w_tmr_nxt;
      r_fs  <= w_lock;
      if (w_load_peak) r_peak <= w_max_nxt;
      if (w_lock) r_bdly <= w_dist;
      if (w_miss) r_miss <= sat_inc8(r_miss);
    end
  end

  // A pending pulse is held through disabled cycles and shown when en returns.
  assign frame_start = r_fs & en;
  assign locked      = (r_state == ST_LOCKED);
  assign peak_a      = r_peak;
  assign b_delay     = r_bdly;
  assign miss_cnt    = r_miss;
  assign o_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_preamble_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofdm_preamble_sync_ctrl
//  Description : Scoreboard bench for the OFDM preamble sync controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ofdm_preamble_sync_ctrl;

  logic        clk;
  logic        reset;
  logic        en;
  logic        rearm;
  logic [47:0] abs_a, porog_a, abs_b, porog_b;
  logic        frame_start, locked;
  logic [47:0] peak_a;
  logic [7:0]  b_delay, miss_cnt;
  logic [2:0]  o_state;

  typedef struct {
    int     edge_no;
    longint peak;
    int     bd;
  } exp_t;

  exp_t sb[$];
  int   g_edge = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   miss_exp = 0;

  ofdm_preamble_sync_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .rearm       (rearm),
    .abs_a       (abs_a),
    .porog_a     (porog_a),
    .abs_b       (abs_b),
    .porog_b     (porog_b),
    .frame_start (frame_start),
    .locked      (locked),
    .peak_a      (peak_a),
    .b_delay     (b_delay),
    .miss_cnt    (miss_cnt),
    .o_state     (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) g_edge <= g_edge + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every frame_start pulse must match the oldest expected lock.
  always @(negedge clk) begin
    if (frame_start === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_frame_start: got pulse at edge %0d expected none", g_edge);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("fs_edge", g_edge, e.edge_no);
        chk("fs_peak_a", peak_a, e.peak);
        chk("fs_b_delay", b_delay, e.bd);
      end
    end
  end

  // One acquisition: A crossing (2000), peak 5000 two cycles later, then an
  // optional B crossing at offset b_at from the first crossing.
  task automatic acq(input int b_at, input int en_off_at, input int rearm_at, input bit hold);
    int   k, d, shift, t0e, n;
    bit   done, lk;
    exp_t e;
    abs_b = '0;
    abs_a = 48'd2000; tick(); t0e = g_edge;
    abs_a = 48'd100;  tick();
    abs_a = 48'd5000; tick();
    abs_a = '0;
    k = 3; shift = 0; done = 0;
    while (!done && k < 40) begin
      if (k == en_off_at) begin
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        shift = 5;
      end
      d     = k - 2;
      abs_b = (k == b_at) ? 48'd3000 : 48'd0;
      rearm = (k == rearm_at);
      lk    = (k == b_at) && (k != rearm_at) && (d >= 14) && (d <= 18);
      if (lk) begin
        e.edge_no = t0e + k + shift;
        e.peak    = 5000;
        e.bd      = d;
        sb.push_back(e);
      end
      tick();
      abs_b = '0;
      rearm = 1'b0;
      if (k == rearm_at) begin
        chk("rearm_state", o_state, 0);
        chk("rearm_peak_a", peak_a, 5000);
        chk("rearm_miss", miss_cnt, miss_exp);
        done = 1;
      end else if (lk) begin
        chk("lock_state", o_state, 3);
        chk("lock_locked", locked, 1);
        if (hold) begin
          n = 0;
          while (locked === 1'b1 && n < 2000) begin
            n++;
            tick();
          end
          chk("locked_len", n, 1024);
          chk("post_lock_state", o_state, 0);
        end
        done = 1;
      end else if (d == 19) begin
        miss_exp = (miss_exp >= 255) ? 255 : miss_exp + 1;
        chk("miss_cnt", miss_cnt, miss_exp);
        chk("timeout_state", o_state, 0);
        done = 1;
      end
      k++;
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; rearm = 1'b0;
    abs_a = '0; abs_b = '0; porog_a = 48'd1024; porog_b = 48'd1024;
    repeat (3) tick();
    chk("rst_state", o_state, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("rst_peak", peak_a, 0);
    reset = 1'b0;
    tick();

    acq(18, 0, 0, 1);   // nominal lock, b_delay 16
    acq(10, 0, 0, 1);   // early B only -> timeout, miss 1
    acq(16, 0, 0, 1);   // window low edge 14
    acq(20, 0, 0, 1);   // window high edge 18
    acq(15, 0, 0, 1);   // 13 -> no lock
    acq(21, 0, 0, 1);   // 19 -> no lock (timeout cycle)
    acq(18, 8, 0, 1);   // en low 5 cycles in WAIT_B -> lock 5 later
    acq(18, 0, 18, 0);  // rearm with valid B same cycle
    repeat (3) tick();
    chk("after_rearm_state", o_state, 0);

    for (int i = 0; i < 300; i++) acq(0, 0, 0, 0);
    chk("miss_saturated", miss_cnt, 255);

    // Reset between clock edges while locked.
    acq(18, 0, 0, 0);
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", o_state, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_peak", peak_a, 0);
    chk("async_rst_bdly", b_delay, 0);
    chk("async_rst_miss", miss_cnt, 0);
    chk("async_rst_fs", frame_start, 0);
    miss_exp = 0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("post_rst_state", o_state, 0);

    repeat (5) tick();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
